sized_data_memory: RTL
======================

SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 64-bit doublewords stored (byte capacity DEPTH*8).
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter LATENCY, default 1, wait cycles between request accept and completion (0..15).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port MemRead, input, 1, load request strobe.
REQ-007 SHALL have port MemWrite, input, 1, store request strobe.
REQ-008 SHALL have port addr, input, ADDR_W, byte address, little-endian.
REQ-009 SHALL have port size, input, 2, access size: 0 byte, 1 half, 2 word, 3 double.
REQ-010 SHALL have port ld_unsigned, input, 1, 1 = zero-extend load, 0 = sign-extend.
REQ-011 SHALL have port write_data, input, 64, store data, low 8/16/32/64 bits used per size.
REQ-012 SHALL have port read_data, output, 64, extended load result, held until next completed load.
REQ-013 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1, high while a request is in flight.
REQ-015 SHALL have port err, output, 1, valid with ready; access faulted.

Function
REQ-016 SHALL use FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-017 SHALL accept a request only in IDLE when MemRead|MemWrite; addr, size, ld_unsigned, write_data, op captured at accept; inputs ignored otherwise.
REQ-018 SHALL treat MemRead&MemWrite together as a store; load ignored.
REQ-019 SHALL stay in WAIT for exactly LATENCY cycles via down-counter; LATENCY=0 skips WAIT (accept -> DONE next edge).
REQ-020 SHALL assert ready for exactly the DONE cycle, i.e. LATENCY+1 cycles after the accept edge; busy high in WAIT and DONE.
REQ-021 SHALL perform the store byte-masked in the DONE cycle edge; only the size-selected bytes change.
REQ-022 SHALL sample loads from the array at DONE; read_data updates on the edge entering DONE and holds afterwards.
REQ-023 SHALL sign- or zero-extend per ld_unsigned for sizes 0-2; size 3 ignores ld_unsigned.
REQ-024 SHALL flag err when addr+bytes > DEPTH*8 (out of range): no write, read_data forced 0.
REQ-025 SHALL allow back-to-back: new request accepted the cycle after DONE (in IDLE); a store followed by a load to the same address returns the stored data.
REQ-026 SHALL initialise the array at time zero to all zero except doubleword 0 = 5; array is not cleared by reset.

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE, counter 0, ready 0, busy 0, err 0, read_data 0.
REQ-028 SHALL abort an in-flight request on reset mid-operation; an aborted store SHALL NOT modify memory.

Configuration
REQ-029 SHALL support macro DMEM_MISALIGN_TRAP_EN: defined -> addr not aligned to size completes with err=1, no write, read_data 0; undefined -> low address bits forced to zero (aligned down) and access completes normally with err=0.

Verification
REQ-030 SHALL check: LATENCY=1, store size 3 value 99 at addr 32, then load size 3 at 32 -> ready 2 cycles after each accept, read_data=99, err=0.
REQ-031 SHALL check: store byte 0xFF at addr 65 over doubleword 0 at 64, load half signed at 64 -> 0xFFFFFFFFFFFFFF00; unsigned -> 0x000000000000FF00.
REQ-032 SHALL check: after power-up load size 3 at addr 0 -> 5; load at addr DEPTH*8 -> err=1, read_data=0.
REQ-033 SHALL check: store word at addr 34 -> with DMEM_MISALIGN_TRAP_EN err=1 and memory unchanged; without it write lands at addr 32, err=0.
REQ-034 SHALL check: assert rst_n low during WAIT of a store to addr 8 -> outputs zero immediately, later load at 8 returns prior value.
REQ-035 SHALL check: LATENCY=0, MemRead held high continuously -> ready every second cycle, busy toggling with it.

Source files
------------

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressable data memory of DEPTH 64-bit doublewords
// with byte/half/word/double loads and stores, a fixed LATENCY completion
// handshake (ready pulse, busy, err) and sign/zero extension of loads.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined a misaligned access
// completes with err=1; when undefined the address is aligned down to the size.
module sized_data_memory #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [63:0]       write_data,
    output logic [63:0]       read_data,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W+1)'(DEPTH * 8);
    localparam logic [3:0]      LAT      = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [63:0]         read_data_q, read_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                store_q, store_d;
    logic [63:0]         wdata_q, wdata_d;

    // Contents survive reset; doubleword 0 powers up holding 5.
    logic [63:0] mem_q [DEPTH] = '{0: 64'd5, default: 64'd0};

    logic [ADDR_W-1:0]   cur_addr;
    logic [1:0]          cur_size;
    logic                cur_uns;
    logic                cur_store;
    logic [63:0]         cur_wdata;
    logic [3:0]          nbytes;
    logic [2:0]          low_mask;
    logic [ADDR_W-1:0]   eff_addr;
    logic [ADDR_W:0]     end_addr;
    logic                fault;
    logic [IDX_W-1:0]    word_idx;
    logic [2:0]          byte_off;
    logic [63:0]         ld_val;
    logic [7:0]          wr_mask;
    logic [63:0]         wr_data;
    logic                wr_en;
    logic                enter_done;

    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [63:0] r;
        case (sz)
            2'd0:    r = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    r = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    r = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] size_bytes_en(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Decode the request being accepted (IDLE) or the captured one (WAIT/DONE).
    always_comb begin
        cur_addr  = (state_q == IDLE) ? addr        : addr_q;
        cur_size  = (state_q == IDLE) ? size        : size_q;
        cur_uns   = (state_q == IDLE) ? ld_unsigned : uns_q;
        cur_store = (state_q == IDLE) ? MemWrite    : store_q;
        cur_wdata = (state_q == IDLE) ? write_data  : wdata_q;

        nbytes   = 4'd1 << cur_size;
        low_mask = 3'(nbytes - 4'd1);
`ifdef DMEM_MISALIGN_TRAP_EN
        eff_addr = cur_addr;
`else
        eff_addr = {cur_addr[ADDR_W-1:3], cur_addr[2:0] & ~low_mask};
`endif
        end_addr = {1'b0, eff_addr} + (ADDR_W+1)'(nbytes);
`ifdef DMEM_MISALIGN_TRAP_EN
        fault    = (end_addr > BYTE_CAP) | (|(cur_addr[2:0] & low_mask));
`else
        fault    = (end_addr > BYTE_CAP);
`endif
        word_idx = eff_addr[3 +: IDX_W];
        byte_off = eff_addr[2:0];

        ld_val  = extend_load(mem_q[word_idx] >> {byte_off, 3'b000}, cur_size, cur_uns);
        wr_mask = size_bytes_en(cur_size) << byte_off;
        wr_data = cur_wdata << {byte_off, 3'b000};
        wr_en   = rst_n & (state_q == DONE) & store_q & ~fault;
    end

    // Next-state, request capture and load result for the IDLE/WAIT/DONE FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        enter_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    addr_d  = addr;
                    size_d  = size;
                    uns_d   = ld_unsigned;
                    store_d = MemWrite;
                    wdata_d = write_data;
                    if (LAT == 4'd0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = DONE;
                    cnt_d      = 4'd0;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Loads sample the array on the edge entering DONE; faults return zero.
        if (enter_done && !cur_store) begin
            read_data_d = fault ? 64'd0 : ld_val;
        end
    end

    // Control state and the visible load result, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            read_data_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
        end
    end

    // Captured request fields; meaningful only while a request is in flight.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        store_q <= store_d;
        wdata_q <= wdata_d;
    end

    // Byte-masked store, committed on the edge that leaves DONE.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign read_data = read_data_q;
    assign ready     = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign err       = (state_q == DONE) & fault;

endmodule
